wb_spi_slave: RTL and testbench

Wishbone-attached SPI target (slave) port: an external SPI master clocks bytes in on mosi and out on miso while the CPU exchanges data through byte-wide TX/RX FIFOs. It sits on the same 32-bit Wishbone peripheral bus as the existing SPI master, with the same register layout style. It lets the SoC be driven by an off-board SPI host such as a debug bridge or a companion MCU. All SPI pins are sampled into the system clock domain; there is no logic clocked by sck.

---
 rtl/wb_spi_slave_pkg.sv | 19 +
 rtl/wb_spi_slave_if.sv | 23 ++
 rtl/fifo.sv | 44 ++++
 rtl/wb_spi_slave_phy.sv | 135 +++++++++++++
 rtl/wb_spi_slave.sv | 137 +++++++++++++
 tb/tb_wb_spi_slave.sv | 269 ++++++++++++++++++++++++++
 6 files changed

// File: rtl/wb_spi_slave_pkg.sv
// Shared register map, status bit positions and PHY state type for wb_spi_slave.
package wb_spi_slave_pkg;

    localparam logic REG_DATA = 1'b0;
    localparam logic REG_CTRL = 1'b1;

    localparam int unsigned RX_EMPTY  = 0;
    localparam int unsigned TX_FULL   = 1;
    localparam int unsigned SS_ACTIVE = 2;
    localparam int unsigned OVERRUN   = 3;
    localparam int unsigned UNDERRUN  = 4;
    localparam int unsigned IRQ_EN    = 5;

    typedef enum logic {
        PHY_IDLE,
        PHY_ACTIVE
    } phy_state_e;

endpackage

// File: rtl/wb_spi_slave_if.sv
// Wishbone peripheral-bus bundle for wb_spi_slave (data in [31:24]).
interface wb_spi_slave_if;

    logic        cyc_i;
    logic        stb_i;
    logic [1:0]  adr_i;
    logic        we_i;
    logic [31:0] dat_i;
    logic [3:0]  sel_i;
    logic [31:0] dat_o;
    logic        ack_o;

    modport master (
        output cyc_i, stb_i, adr_i, we_i, dat_i, sel_i,
        input  dat_o, ack_o
    );

    modport slave (
        input  cyc_i, stb_i, adr_i, we_i, dat_i, sel_i,
        output dat_o, ack_o
    );

endinterface

// File: rtl/fifo.sv
// Byte FIFO with first-word-fall-through head; SIZE must be a power of two >= 2.
module fifo #(
    parameter int unsigned SIZE = 16,
    parameter int unsigned DW   = 8
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          push_i,
    input  logic [DW-1:0] data_i,
    input  logic          pop_i,
    output logic [DW-1:0] data_o,
    output logic          full_o,
    output logic          empty_o
);

    localparam int unsigned AW      = $clog2(SIZE);
    localparam logic [AW:0] PTR_ONE = 1;

    logic [DW-1:0] mem_q [SIZE];
    logic [AW:0]   wr_ptr_q, rd_ptr_q;
    logic          do_push, do_pop;

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign data_o  = mem_q[rd_ptr_q[AW-1:0]];
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= data_i;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
        end
    end

endmodule

// File: rtl/wb_spi_slave_phy.sv
// SPI mode-0 target PHY: pin synchronizers, edge detect, bit counter and shifters,
// all in the clk_i domain, with a valid/ready byte interface towards the FIFOs.
module spi_slave_phy
    import wb_spi_slave_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       sck_i,
    input  logic       ss_i,
    input  logic       mosi_i,
    output logic       miso_o,
    input  logic       tx_valid_i,
    input  logic [7:0] tx_data_i,
    output logic       tx_ready_o,
    output logic       rx_valid_o,
    output logic [7:0] rx_data_o,
    input  logic       rx_ready_i,
    output logic       underrun_o,
    output logic       overrun_o,
    output logic       active_o
);

    logic [2:0] sck_q, ss_q;
    logic [1:0] mosi_q;
    logic       sck_rise, sck_fall, ss_fall, ss_high;

    phy_state_e state_q, state_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] rx_shift_q, rx_shift_d;
    logic [7:0] tx_shift_q, tx_shift_d;
    logic       byte_done_q, byte_done_d;
    logic       miso_q, miso_d;
    logic       tx_load;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sck_q  <= '0;
            ss_q   <= '1;
            mosi_q <= '0;
        end else begin
            sck_q  <= {sck_q[1:0], sck_i};
            ss_q   <= {ss_q[1:0], ss_i};
            mosi_q <= {mosi_q[0], mosi_i};
        end
    end

    assign sck_rise = sck_q[1] & ~sck_q[2];
    assign sck_fall = ~sck_q[1] & sck_q[2];
    assign ss_fall  = ~ss_q[1] & ss_q[2];
    assign ss_high  = ss_q[1];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= PHY_IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            PHY_IDLE:   if (ss_fall) state_d = PHY_ACTIVE;
            PHY_ACTIVE: if (ss_high) state_d = PHY_IDLE;
        endcase
    end

    // byte_done marks that the 8th rise happened, so the next fall loads a fresh TX byte
    always_comb begin
        bit_cnt_d   = bit_cnt_q;
        rx_shift_d  = rx_shift_q;
        tx_shift_d  = tx_shift_q;
        byte_done_d = byte_done_q;
        miso_d      = miso_q;
        tx_load     = 1'b0;
        rx_valid_o  = 1'b0;
        unique case (state_q)
            PHY_IDLE: begin
                bit_cnt_d   = '0;
                rx_shift_d  = '0;
                byte_done_d = 1'b0;
                miso_d      = 1'b1;
                tx_load     = ss_fall;
            end
            PHY_ACTIVE: begin
                if (ss_high) begin
                    bit_cnt_d   = '0;
                    rx_shift_d  = '0;
                    byte_done_d = 1'b0;
                    miso_d      = 1'b1;
                end else if (sck_rise) begin
                    rx_shift_d = {rx_shift_q[6:0], mosi_q[1]};
                    bit_cnt_d  = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        rx_valid_o  = 1'b1;
                        byte_done_d = 1'b1;
                    end
                end else if (sck_fall) begin
                    if (byte_done_q) begin
                        tx_load     = 1'b1;
                        byte_done_d = 1'b0;
                    end else begin
                        tx_shift_d = {tx_shift_q[6:0], 1'b0};
                        miso_d     = tx_shift_q[6];
                    end
                end
            end
        endcase
        if (tx_load) begin
            tx_shift_d = tx_valid_i ? tx_data_i : 8'h00;
            miso_d     = tx_shift_d[7];
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            bit_cnt_q   <= '0;
            rx_shift_q  <= '0;
            tx_shift_q  <= '0;
            byte_done_q <= 1'b0;
            miso_q      <= 1'b1;
        end else begin
            bit_cnt_q   <= bit_cnt_d;
            rx_shift_q  <= rx_shift_d;
            tx_shift_q  <= tx_shift_d;
            byte_done_q <= byte_done_d;
            miso_q      <= miso_d;
        end
    end

    assign rx_data_o  = {rx_shift_q[6:0], mosi_q[1]};
    assign tx_ready_o = tx_load & tx_valid_i;
    assign underrun_o = tx_load & ~tx_valid_i;
    assign overrun_o  = rx_valid_o & ~rx_ready_i;
    assign miso_o     = miso_q;
    assign active_o   = (state_q == PHY_ACTIVE);

endmodule

// File: rtl/wb_spi_slave.sv
// Wishbone SPI target with byte TX/RX FIFOs. Define SPI_SLAVE_IRQ_EN to add the
// irq_o port and a writable irq_en control bit.
module wb_spi_slave
    import wb_spi_slave_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 1024
) (
    input  logic           clk_i,
    input  logic           rst_ni,
    wb_spi_slave_if.slave  wb,
    input  logic           sck,
    input  logic           ss,
    input  logic           mosi,
    output logic           miso
`ifdef SPI_SLAVE_IRQ_EN
    ,
    output logic           irq_o
`endif
);

    logic       ack_q, ack_d;
    logic       overrun_q, overrun_d, underrun_q, underrun_d;
    logic       irq_en;
    logic       acc, data_acc, ctrl_wr;
    logic       tx_push, tx_pop, tx_full, tx_empty;
    logic [7:0] tx_head;
    logic       rx_push, rx_pop, rx_full, rx_empty;
    logic [7:0] rx_head, rx_byte;
    logic       phy_underrun, phy_overrun, ss_active;
    logic [7:0] status, rd_byte;
    logic       unused_bits;

    assign ack_d    = wb.stb_i & ~ack_q;
    assign acc      = ack_q & wb.cyc_i & wb.stb_i;
    assign data_acc = acc & (wb.adr_i[0] == REG_DATA);
    assign ctrl_wr  = acc & (wb.adr_i[0] == REG_CTRL) & wb.we_i;
    assign tx_push  = data_acc & wb.we_i;
    assign rx_pop   = data_acc & ~wb.we_i & ~rx_empty;

    always_comb begin
        overrun_d  = overrun_q;
        underrun_d = underrun_q;
        if (ctrl_wr && wb.dat_i[24]) begin
            overrun_d  = 1'b0;
            underrun_d = 1'b0;
        end
        if (phy_overrun)  overrun_d  = 1'b1;
        if (phy_underrun) underrun_d = 1'b1;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ack_q      <= 1'b0;
            overrun_q  <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            ack_q      <= ack_d;
            overrun_q  <= overrun_d;
            underrun_q <= underrun_d;
        end
    end

`ifdef SPI_SLAVE_IRQ_EN
    logic irq_en_q, irq_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            irq_en_q <= 1'b0;
            irq_q    <= 1'b0;
        end else begin
            if (ctrl_wr) irq_en_q <= wb.dat_i[25];
            irq_q <= irq_en_q & (~rx_empty | overrun_q | underrun_q);
        end
    end

    assign irq_en = irq_en_q;
    assign irq_o  = irq_q;
`else
    assign irq_en = 1'b0;
`endif

    always_comb begin
        status            = '0;
        status[RX_EMPTY]  = rx_empty;
        status[TX_FULL]   = tx_full;
        status[SS_ACTIVE] = ss_active;
        status[OVERRUN]   = overrun_q;
        status[UNDERRUN]  = underrun_q;
        status[IRQ_EN]    = irq_en;
    end

    assign rd_byte     = (wb.adr_i[0] == REG_CTRL) ? status : rx_head;
    assign wb.dat_o    = ack_q ? {rd_byte, 24'h0} : '0;
    assign wb.ack_o    = ack_q;
    assign unused_bits = ^{wb.sel_i, wb.adr_i[1], wb.dat_i[23:0], tx_empty};

    fifo #(.SIZE(FIFO_DEPTH), .DW(8)) u_tx_fifo (
        .clk_i   (clk_i),
        .rst_i   (~rst_ni),
        .push_i  (tx_push),
        .data_i  (wb.dat_i[31:24]),
        .pop_i   (tx_pop),
        .data_o  (tx_head),
        .full_o  (tx_full),
        .empty_o (tx_empty)
    );

    fifo #(.SIZE(FIFO_DEPTH), .DW(8)) u_rx_fifo (
        .clk_i   (clk_i),
        .rst_i   (~rst_ni),
        .push_i  (rx_push),
        .data_i  (rx_byte),
        .pop_i   (rx_pop),
        .data_o  (rx_head),
        .full_o  (rx_full),
        .empty_o (rx_empty)
    );

    spi_slave_phy u_phy (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .sck_i      (sck),
        .ss_i       (ss),
        .mosi_i     (mosi),
        .miso_o     (miso),
        .tx_valid_i (~tx_empty),
        .tx_data_i  (tx_head),
        .tx_ready_o (tx_pop),
        .rx_valid_o (rx_push),
        .rx_data_o  (rx_byte),
        .rx_ready_i (~rx_full),
        .underrun_o (phy_underrun),
        .overrun_o  (phy_overrun),
        .active_o   (ss_active)
    );

endmodule

// File: tb/tb_wb_spi_slave.sv
// Directed bench for wb_spi_slave (FIFO_DEPTH=4); acts as Wishbone CPU and SPI mode-0 master.
module tb_wb_spi_slave;

    localparam int unsigned HALF = 8;

    logic clk = 1'b0;
    logic rst_n;
    logic sck, ss, mosi, miso;
`ifdef SPI_SLAVE_IRQ_EN
    logic irq;
`endif

    wb_spi_slave_if wbif ();

    wb_spi_slave #(.FIFO_DEPTH(4)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .wb     (wbif),
        .sck    (sck),
        .ss     (ss),
        .mosi   (mosi),
        .miso   (miso)
`ifdef SPI_SLAVE_IRQ_EN
        ,
        .irq_o  (irq)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       pre;
        logic [7:0] tx;
        logic [7:0] mosi_b;
        logic [7:0] exp_miso;
        logic [7:0] exp_rx;
    } vec_t;

    vec_t        vecs [6];
    int unsigned n_checks = 0;
    int unsigned n_err    = 0;
    logic [31:0] rd;
    logic [7:0]  got;
    logic [7:0]  mb [5];
    logic [7:0]  sb [5];

    task automatic wait_clk(input int unsigned n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic wb_xfer(input logic adr0, input logic we, input logic [31:0] wdat,
                           output logic [31:0] rdat);
        int unsigned n;
        wbif.cyc_i = 1'b1;
        wbif.stb_i = 1'b1;
        wbif.adr_i = {1'b0, adr0};
        wbif.we_i  = we;
        wbif.dat_i = wdat;
        wbif.sel_i = '1;
        n = 0;
        rdat = '0;
        do begin
            wait_clk(1);
            n++;
        end while (wbif.ack_o !== 1'b1 && n < 6);
        check("wb_ack", {31'b0, wbif.ack_o}, 32'd1);
        rdat = wbif.dat_o;
        wait_clk(1);
        wbif.cyc_i = 1'b0;
        wbif.stb_i = 1'b0;
        wbif.we_i  = 1'b0;
    endtask

    task automatic wb_write(input logic adr0, input logic [7:0] b);
        logic [31:0] dummy;
        wb_xfer(adr0, 1'b1, {b, 24'h0}, dummy);
    endtask

    task automatic chk_status(input string name, input logic [7:0] exp);
        logic [31:0] r;
        wb_xfer(1'b1, 1'b0, 32'h0, r);
        check(name, r, {exp, 24'h0});
    endtask

    task automatic chk_data(input string name, input logic [7:0] exp);
        logic [31:0] r;
        wb_xfer(1'b0, 1'b0, 32'h0, r);
        check(name, r, {exp, 24'h0});
    endtask

    task automatic ss_begin();
        ss = 1'b0;
        wait_clk(16);
    endtask

    task automatic ss_end();
        wait_clk(HALF);
        ss = 1'b1;
        wait_clk(16);
    endtask

    task automatic spi_bits(input logic [7:0] tx, input int unsigned nbits, output logic [7:0] rx);
        rx = '0;
        for (int unsigned i = 0; i < nbits; i++) begin
            mosi = tx[7-i];
            wait_clk(HALF);
            sck = 1'b1;
            rx[7-i] = miso;
            wait_clk(HALF);
            sck = 1'b0;
        end
    endtask

    initial begin
        #500us;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{1'b1, 8'hA5, 8'h12, 8'hA5, 8'h12};
        vecs[1] = '{1'b1, 8'h3C, 8'h34, 8'h3C, 8'h34};
        vecs[2] = '{1'b1, 8'hFF, 8'h00, 8'hFF, 8'h00};
        vecs[3] = '{1'b1, 8'h00, 8'hFF, 8'h00, 8'hFF};
        vecs[4] = '{1'b1, 8'h81, 8'h7E, 8'h81, 8'h7E};
        vecs[5] = '{1'b0, 8'h00, 8'h55, 8'h00, 8'h55};

        wbif.cyc_i = 1'b0;
        wbif.stb_i = 1'b0;
        wbif.adr_i = '0;
        wbif.we_i  = 1'b0;
        wbif.dat_i = '0;
        wbif.sel_i = '0;
        sck = 1'b0; ss = 1'b1; mosi = 1'b0;
        rst_n = 1'b0;
        wait_clk(5);
        check("rst_ack", {31'b0, wbif.ack_o}, 32'd0);
        check("rst_dat", wbif.dat_o, 32'd0);
        check("rst_miso", {31'b0, miso}, 32'd1);
`ifdef SPI_SLAVE_IRQ_EN
        check("rst_irq", {31'b0, irq}, 32'd0);
`endif
        rst_n = 1'b1;
        wait_clk(5);
        chk_status("rst_status", 8'h01);

        // Single-byte frames; trailing fall after the 8th bit always underruns an empty TX FIFO
        for (int unsigned v = 0; v < 6; v++) begin
            if (vecs[v].pre) wb_write(1'b0, vecs[v].tx);
            ss_begin();
            spi_bits(vecs[v].mosi_b, 8, got);
            ss_end();
            check($sformatf("vec%0d_miso", v), {24'h0, got}, {24'h0, vecs[v].exp_miso});
            check($sformatf("vec%0d_idle_miso", v), {31'b0, miso}, 32'd1);
            chk_status($sformatf("vec%0d_stat_full", v), 8'h10);
            chk_data($sformatf("vec%0d_rx", v), vecs[v].exp_rx);
            chk_status($sformatf("vec%0d_stat_empty", v), 8'h11);
            wb_write(1'b1, 8'h01);
            chk_status($sformatf("vec%0d_stat_clr", v), 8'h01);
        end

        // Two-byte frame
        wb_write(1'b0, 8'hA5);
        wb_write(1'b0, 8'h3C);
        ss_begin();
        chk_status("two_ss_active", 8'h05);
        spi_bits(8'h12, 8, got);
        check("two_miso0", {24'h0, got}, 32'hA5);
        spi_bits(8'h34, 8, got);
        check("two_miso1", {24'h0, got}, 32'h3C);
        ss_end();
        chk_data("two_rx0", 8'h12);
        chk_data("two_rx1", 8'h34);
        chk_status("two_status", 8'h11);
        wb_write(1'b1, 8'h01);
        chk_status("two_clr", 8'h01);

        // TX overfill drop, then RX overfill -> overrun with contents intact
        for (int unsigned i = 0; i < 5; i++) wb_write(1'b0, 8'hA1 + 8'(i));
        chk_status("txfull_status", 8'h03);
        mb[0] = 8'h10; mb[1] = 8'h11; mb[2] = 8'h12; mb[3] = 8'h13; mb[4] = 8'h99;
        sb[0] = 8'hA1; sb[1] = 8'hA2; sb[2] = 8'hA3; sb[3] = 8'hA4; sb[4] = 8'h00;
        ss_begin();
        for (int unsigned i = 0; i < 5; i++) begin
            spi_bits(mb[i], 8, got);
            check($sformatf("ovf_miso%0d", i), {24'h0, got}, {24'h0, sb[i]});
        end
        ss_end();
        chk_status("ovf_status", 8'h18);
        for (int unsigned i = 0; i < 4; i++) chk_data($sformatf("ovf_rx%0d", i), mb[i]);
        chk_status("ovf_drained", 8'h19);
        wb_write(1'b1, 8'h01);
        chk_status("ovf_clr", 8'h01);

        // Partial frame is discarded and the next frame realigns
        wb_write(1'b0, 8'h5A);
        ss_begin();
        spi_bits(8'hFF, 5, got);
        ss_end();
        chk_status("part_status", 8'h01);
        wb_write(1'b0, 8'hC3);
        ss_begin();
        spi_bits(8'h81, 8, got);
        ss_end();
        check("part_miso", {24'h0, got}, 32'hC3);
        chk_status("part_full", 8'h10);
        chk_data("part_rx", 8'h81);
        chk_status("part_empty", 8'h11);
        wb_write(1'b1, 8'h01);

        // Reset mid-byte flushes FIFOs and returns pins/bus to idle
        wb_write(1'b0, 8'h77);
        wb_write(1'b0, 8'h66);
        ss_begin();
        spi_bits(8'hAA, 4, got);
        rst_n = 1'b0;
        ss = 1'b1;
        sck = 1'b0;
        wait_clk(1);
        check("mrst_miso", {31'b0, miso}, 32'd1);
        check("mrst_ack", {31'b0, wbif.ack_o}, 32'd0);
        check("mrst_dat", wbif.dat_o, 32'd0);
        wait_clk(4);
        rst_n = 1'b1;
        wait_clk(4);
        check("mrst_miso_after", {31'b0, miso}, 32'd1);
        chk_status("mrst_status", 8'h01);
        ss_begin();
        spi_bits(8'h3C, 8, got);
        ss_end();
        check("mrst_tx_flushed", {24'h0, got}, 32'h00);
        chk_data("mrst_rx", 8'h3C);
        chk_status("mrst_status2", 8'h11);
        wb_write(1'b1, 8'h01);

        // irq_en bit: writable only when the interrupt build is enabled
        wb_write(1'b1, 8'h02);
`ifdef SPI_SLAVE_IRQ_EN
        chk_status("irqen_status", 8'h21);
        wait_clk(2);
        check("irq_idle", {31'b0, irq}, 32'd0);
        ss_begin();
        spi_bits(8'h42, 8, got);
        ss_end();
        wb_write(1'b1, 8'h03);
        wait_clk(2);
        check("irq_rx", {31'b0, irq}, 32'd1);
        chk_data("irq_data", 8'h42);
        wait_clk(2);
        check("irq_drained", {31'b0, irq}, 32'd0);
        wb_write(1'b1, 8'h00);
`else
        chk_status("irqen_status", 8'h01);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
